// File: rtl/mux_n_reg.sv
// mux_n_reg: parametrised N-input, WIDTH-bit datapath selector.
// The selected value is captured in an explicit hold register on load.
// The block also provides a one-cycle valid strobe, a sticky select-error
// flag and the last valid select code.
// With REGISTERED=0, a valid select is passed through combinationally.
// An out-of-range select always falls back to the hold register.
module mux_n_reg #(
    parameter int               WIDTH      = 32,
    parameter int               NUM_IN     = 3,
    parameter int               SEL_W      = 2,
    parameter bit               REGISTERED = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        last_sel
);

    // The extra bit lets NUM_IN == 2**SEL_W be represented.
    // In that case every code is valid and sel_ok is constant 1.
    localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

    logic             sel_ok;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] hold;

    assign sel_ok = ({1'b0, sel} < NUM_IN_C);

    // Pick input[sel]. The zero default for unused codes keeps this a pure mux.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Hold register, strobe, last select and sticky error flag.
    // When the error flag is set and cleared in the same cycle, set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold      <= RESET_VAL;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            last_sel  <= '0;
        end else begin
            out_valid <= load && sel_ok;
            if (load && sel_ok) begin
                hold     <= sel_data;
                last_sel <= sel;
            end
            if (load && !sel_ok) begin
                sel_err <= 1'b1;
            end else if (clr_err) begin
                sel_err <= 1'b0;
            end
        end
    end

    generate
        if (REGISTERED) begin : g_registered
            assign out = hold;
        end else begin : g_comb
            assign out = sel_ok ? sel_data : hold;
        end
    endgenerate

endmodule

// File: tb/tb_mux_n_reg.sv
// Testbench for mux_n_reg.
// It drives three instances from shared control inputs:
//   - the default registered 3x32 selector (dut_r)
//   - a combinational-output 3x32 selector (dut_c)
//   - a full-code 4x8 selector with a nonzero reset value (dut_f)
// Expected values come from a hand-built vector table and a behavioural model.
module tb_mux_n_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] in_data;
    logic [31:0] in_data_f;
    logic [1:0]  sel;
    logic        load;
    logic        clr_err;

    logic [31:0] out_r, out_c;
    logic [7:0]  out_f;
    logic        valid_r, valid_c, valid_f;
    logic        err_r, err_c, err_f;
    logic [1:0]  last_r, last_c, last_f;

    int tests = 0;
    int fails = 0;

    // Behavioural model state for the 3-input instances and the 4-input instance.
    logic [31:0] m_in [3];
    logic [31:0] m_hold;
    logic        m_valid, m_err;
    logic [1:0]  m_last;
    logic [7:0]  mf_in [4];
    logic [7:0]  mf_hold;
    logic        mf_valid;
    logic [1:0]  mf_last;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [1:0]  s;
        logic        clr;
        logic [31:0] i0, i1, i2;
        logic [31:0] eout;
        logic        ev;
        logic        ee;
        logic [1:0]  el;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    mux_n_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .REGISTERED(1'b1), .RESET_VAL(32'h0)) dut_r (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .load(load), .clr_err(clr_err),
        .out(out_r), .out_valid(valid_r), .sel_err(err_r), .last_sel(last_r));

    mux_n_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .REGISTERED(1'b0), .RESET_VAL(32'h0)) dut_c (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .load(load), .clr_err(clr_err),
        .out(out_c), .out_valid(valid_c), .sel_err(err_c), .last_sel(last_c));

    mux_n_reg #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .REGISTERED(1'b1), .RESET_VAL(8'h5A)) dut_f (
        .clk(clk), .reset(reset), .in_data(in_data_f), .sel(sel), .load(load), .clr_err(clr_err),
        .out(out_f), .out_valid(valid_f), .sel_err(err_f), .last_sel(last_f));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply the selector rules to whatever inputs were present at this edge.
    task automatic modelUpdate();
        if (reset) begin
            m_hold = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_last = 2'd0;
            mf_hold = 8'h5A; mf_valid = 1'b0; mf_last = 2'd0;
        end else begin
            m_valid = load && (sel < 2'd3);
            if (m_valid) begin
                m_hold = m_in[sel];
                m_last = sel;
            end
            if (load && sel == 2'd3) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
            mf_valid = load;
            if (load) begin
                mf_hold = mf_in[sel];
                mf_last = sel;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic ld, input logic [1:0] s, input logic clr,
                                 input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2);
        reset = rst; load = ld; sel = s; clr_err = clr;
        m_in[0] = i0; m_in[1] = i1; m_in[2] = i2;
        in_data = {i2, i1, i0};
        in_data_f = $urandom;
        for (int k = 0; k < 4; k++) mf_in[k] = in_data_f[k*8 +: 8];
    endtask

    // Compare every instance against the behavioural model.
    task automatic checkOutput(input string tag);
        logic [31:0] comb_exp;
        comb_exp = (sel < 2'd3) ? m_in[sel] : m_hold;
        check({tag, ".r.out"},   out_r,   m_hold);
        check({tag, ".r.valid"}, 32'(valid_r), 32'(m_valid));
        check({tag, ".r.err"},   32'(err_r),   32'(m_err));
        check({tag, ".r.last"},  32'(last_r),  32'(m_last));
        check({tag, ".c.out"},   out_c,   comb_exp);
        check({tag, ".c.valid"}, 32'(valid_c), 32'(m_valid));
        check({tag, ".c.err"},   32'(err_c),   32'(m_err));
        check({tag, ".c.last"},  32'(last_c),  32'(m_last));
        check({tag, ".f.out"},   32'(out_f),   32'(mf_hold));
        check({tag, ".f.valid"}, 32'(valid_f), 32'(mf_valid));
        check({tag, ".f.err"},   32'(err_f),   32'h0);
        check({tag, ".f.last"},  32'(last_f),  32'(mf_last));
    endtask

    initial begin
        // Values after each edge for the registered 3x32 instance.
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h22222222, 1'b1, 1'b0, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 1'b1, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 1'b0, 1'b1, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 2'd3, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 1'b0, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 1'b0, 1'b1, 2'd2};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'h33333333, 1'b0, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h33333333, 1'b0, 1'b0, 2'd2};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h76543210, 32'hFEDCBA98, 32'h00000000, 32'h33333333, 1'b0, 1'b0, 2'd2};
        vecs[10] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h55555555, 32'hAAAAAAAA, 32'h12121212, 32'h33333333, 1'b0, 1'b0, 2'd2};
        vecs[11] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 32'h00000000, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 1'b1, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 1'b0, 1'b0, 2'd0};

        m_hold = '0; m_valid = 1'b0; m_err = 1'b0; m_last = '0;
        mf_hold = '0; mf_valid = 1'b0; mf_last = '0;

        // Table-driven directed vectors, checked against the table and the model.
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].ld, vecs[v].s, vecs[v].clr, vecs[v].i0, vecs[v].i1, vecs[v].i2);
            step();
            check($sformatf("vec%0d.out", v),   out_r,         vecs[v].eout);
            check($sformatf("vec%0d.valid", v), 32'(valid_r),  32'(vecs[v].ev));
            check($sformatf("vec%0d.err", v),   32'(err_r),    32'(vecs[v].ee));
            check($sformatf("vec%0d.last", v),  32'(last_r),   32'(vecs[v].el));
            checkOutput($sformatf("vec%0d", v));
        end

        // Combinational pass-through: load 0x22222222, then exercise sel without clocking.
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333);
        step();
        check("comb.hold", out_c, 32'h22222222);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'hAAAA5555, 32'h22222222, 32'h33333333);
        #1;
        check("comb.sel0", out_c, 32'hAAAA5555);
        check("comb.reg_unchanged", out_r, 32'h22222222);
        sel = 2'd3;
        #1;
        check("comb.sel3", out_c, 32'h22222222);
        in_data[31:0] = 32'h0;
        m_in[0] = 32'h0;
        #1;
        check("comb.sel3_in0_zero", out_c, 32'h22222222);
        step();
        checkOutput("comb.after");

        // Randomised run against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom);
            step();
            checkOutput($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
